ss_chunk_endpoint: RTL and testbench
====================================

// Module: ss_chunk_endpoint
// PURPOSE
//  Client-side endpoint for one save-state chunk: exposes a synchronous RAM as a chunk to the
//  save-state streamer. Answers header queries (length/width) on save, validates headers on restore,
//  then serves element reads/writes addressed by chunk_address. One instance per chunk_select bit.
// PARAMETERS
//  ADDR_W        12    RAM address width
//  WIDTH_CODE    1     element width code: 0=8b 1=16b 2=32b 3=64b; DATA_W = 8<<WIDTH_CODE
//  LENGTH        4096  chunk length in elements (<= 2**ADDR_W)
//  READ_LATENCY  1     RAM read latency in cycles, legal 1..4
// PORTS
//  clk           in   1       clock
//  reset         in   1       reset
//  ss_select     in   1       this chunk selected (streamer chunk_select bit)
//  ss_query      in   1       header phase qualifier
//  ss_wr_req     in   1       restore request (header check or element write)
//  ss_rd_req     in   1       save request (header fetch or element read)
//  ss_addr       in   32      element index (chunk_address)
//  ss_wdata      in   64      header or element data, element in low DATA_W bits
//  ss_rdata      out  64      header or element data, zero-extended
//  ss_ack        out  1       one-cycle acknowledge (streamer data_ack bit)
//  mem_addr      out  ADDR_W  RAM address
//  mem_we        out  1       RAM write strobe
//  mem_wdata     out  DATA_W  RAM write data
//  mem_rdata     in   DATA_W  RAM read data, valid READ_LATENCY cycles after mem_addr
//  core_* (SS_CORE_ARB_EN only): core_addr in ADDR_W, core_we in 1, core_wdata in DATA_W, core_req in 1
// BEHAVIOUR
//  reset: synchronous, active-high; clock: clk. Outputs after reset: ss_ack=0, ss_rdata=0, mem_we=0,
//   mem_addr=0, mem_wdata=0; state IDLE.
//  Accept: request taken only in IDLE when ss_select & (ss_rd_req|ss_wr_req) & ~ss_ack; rd wins if both.
//  ss_ack is high exactly one cycle per accepted request; the next request needs a fresh req after ack.
//  States: IDLE -> HDR (query) | RD_WAIT (read) | WR (write) -> ACK -> IDLE.
//  Header read (query&rd): ss_rdata = {30'b0, WIDTH_CODE[1:0], LENGTH[31:0]}; ack 1 cycle after accept.
//  Header check (query&wr): ack 1 cycle after accept iff ss_wdata[31:0]==LENGTH and
//   ss_wdata[33:32]==WIDTH_CODE; on mismatch no ack, return to IDLE (streamer times out at 16 cycles
//   and skips the chunk). Total response must stay <16 cycles.
//  Element read: mem_addr=ss_addr[ADDR_W-1:0] on accept cycle; ss_rdata captured from mem_rdata after
//   READ_LATENCY cycles, ack on the following cycle (latency READ_LATENCY+1 from accept).
//  Element write: mem_we=1 for one cycle with mem_wdata=ss_wdata[DATA_W-1:0]; ack next cycle.
//  Out of range (ss_addr >= LENGTH): read returns 0 with normal ack timing, no RAM access;
//   write is acked but mem_we stays 0.
//  ss_select falls mid-operation: abort to IDLE, no ack, pending RAM read result discarded.
//  Reset mid-operation: immediate return to reset values; any in-flight write already issued stands.
//  ss_addr upper bits beyond ADDR_W ignored except for the range check (32-bit compare).
// CONFIGURATION
//  SS_CORE_ARB_EN defined: core_* ports exist; RAM port muxed, core has priority. When core_req=1 the
//   endpoint holds its pending access (extra cycles, still bounded by caller) and mem_* follow core_*;
//   ack latency grows by stalled cycles. Header phases never stall.
//  SS_CORE_ARB_EN undefined: no core_* ports; endpoint owns mem_* outright; mem_addr/mem_we idle at 0.
// STRUCTURE
//  Shared package ss_pkg: width-code enum (SS_W8..SS_W64), header field ranges (LEN 31:0, WIDTH 33:32,
//   INDEX 63:56), end-marker constant 64'hFFFF_FFFF_FFFF_FFFF, timeout constant 16.
//  One sub-module: ss_rd_pipe (READ_LATENCY-deep valid shift register, cleared on abort/reset).
// TESTING
//  Header fetch: WIDTH_CODE=1, LENGTH=4096, select+query+rd_req -> 1 cycle later ack, rdata=64'h1_0000_1000.
//  Header check: wdata=64'h1_0000_1000 -> ack; wdata=64'h1_0000_0FFF -> no ack within 16 cycles.
//  Read, READ_LATENCY=2: RAM[5]=16'hBEEF, addr=5 -> ack at accept+3, rdata=64'h0000_0000_0000_BEEF.
//  Write: addr=7, wdata=64'hDEAD_0000_0000_1234 -> mem_we one cycle, mem_wdata=16'h1234, ack next cycle.
//  Range: addr=4096 read -> rdata=0 ack, no mem access; write -> ack, mem_we never high.
//  Abort/arb: drop select 1 cycle after read accept -> no ack; with SS_CORE_ARB_EN core_req held
//   3 cycles during write -> mem follows core, endpoint write issues after, ack 3 cycles late.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared save-state definitions: width codes, header field positions, FSM states and header packing.
package ss_pkg;

   typedef enum logic [1:0] {SS_W8, SS_W16, SS_W32, SS_W64} ss_width_e;

   typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_RD_WAIT, ST_WR, ST_ACK} ss_state_e;

   localparam int unsigned SS_HDR_LEN_LSB     = 0;
   localparam int unsigned SS_HDR_LEN_MSB     = 31;
   localparam int unsigned SS_HDR_WIDTH_LSB   = 32;
   localparam int unsigned SS_HDR_WIDTH_MSB   = 33;
   localparam int unsigned SS_HDR_INDEX_LSB   = 56;
   localparam int unsigned SS_HDR_INDEX_MSB   = 63;
   localparam logic [63:0] SS_END_MARKER      = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam int unsigned SS_TIMEOUT         = 16;

   function automatic logic [63:0] ss_hdr_word(input logic [1:0] width, input logic [31:0] length);
      return {30'b0, width, length};
   endfunction

endpackage

// File: rtl/ss_rd_pipe.sv
// Tracks an issued RAM read through READ_LATENCY cycles; valid marks the cycle mem_rdata is usable.
module ss_rd_pipe #(
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic push,
   output logic valid
);

   logic [READ_LATENCY-1:0] stage;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         stage <= '0;
      end else begin
         stage[0] <= push;
         for (int i = 1; i < int'(READ_LATENCY); i++) stage[i] <= stage[i-1];
      end
   end

   assign valid = stage[READ_LATENCY-1];

endmodule

// File: rtl/ss_chunk_endpoint.sv
// Save-state chunk endpoint: serves header queries and element access to a synchronous RAM.
// Optional SS_CORE_ARB_EN shares the RAM port with a core that has priority.
module ss_chunk_endpoint
   import ss_pkg::*;
#(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned WIDTH_CODE   = 1,
   parameter int unsigned LENGTH       = 4096,
   parameter int unsigned READ_LATENCY = 1,
   localparam int unsigned DATA_W      = 8 << WIDTH_CODE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ss_select,
   input  logic              ss_query,
   input  logic              ss_wr_req,
   input  logic              ss_rd_req,
   input  logic [31:0]       ss_addr,
   input  logic [63:0]       ss_wdata,
   output logic [63:0]       ss_rdata,
   output logic              ss_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef SS_CORE_ARB_EN
   ,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_we,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic              core_req
`endif
);

   localparam logic [1:0]  WCODE = 2'(WIDTH_CODE);
   localparam logic [31:0] LEN32 = 32'(LENGTH);

   ss_state_e         state;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic              pend;
   logic              oor;
   logic              hdr_ok;
   logic              hdr_rd;
   logic              rd_issue;
   logic              rd_valid;
   logic              core_busy;
   logic              accept;
   logic              in_range;
   logic              hdr_match;
   logic              abort;
   logic              unused_wdata;

`ifdef SS_CORE_ARB_EN
   assign core_busy = core_req;
`else
   assign core_busy = 1'b0;
`endif

   assign accept    = (state == ST_IDLE) && ss_select && (ss_rd_req || ss_wr_req) && !ss_ack;
   assign in_range  = ss_addr < LEN32;
   assign hdr_match = (ss_wdata[SS_HDR_WIDTH_MSB:SS_HDR_WIDTH_LSB] == WCODE) &&
                      (ss_wdata[SS_HDR_LEN_MSB:SS_HDR_LEN_LSB] == LEN32);
   assign abort     = !ss_select && (state inside {ST_HDR, ST_RD_WAIT, ST_WR});
   assign unused_wdata = ^ss_wdata;

   ss_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_pipe (
      .clk   (clk),
      .reset (reset),
      .clear (abort),
      .push  (rd_issue),
      .valid (rd_valid)
   );

   // RAM strobes are single-cycle pulses; out-of-range accesses time normally but never touch the RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ss_ack    <= 1'b0;
         ss_rdata  <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         p_addr    <= '0;
         p_wdata   <= '0;
         pend      <= 1'b0;
         oor       <= 1'b0;
         hdr_ok    <= 1'b0;
         hdr_rd    <= 1'b0;
         rd_issue  <= 1'b0;
      end else begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         rd_issue  <= 1'b0;
`ifdef SS_CORE_ARB_EN
         if (core_req) begin
            mem_addr  <= core_addr;
            mem_we    <= core_we;
            mem_wdata <= core_wdata;
         end
`endif
         if (abort) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     p_addr  <= ss_addr[ADDR_W-1:0];
                     p_wdata <= ss_wdata[DATA_W-1:0];
                     oor     <= !in_range;
                     hdr_ok  <= hdr_match;
                     hdr_rd  <= ss_rd_req;
                     pend    <= core_busy && !ss_query;
                     if (ss_query) begin
                        state <= ST_HDR;
                     end else if (ss_rd_req) begin
                        state <= ST_RD_WAIT;
                        if (!core_busy) begin
                           if (in_range) mem_addr <= ss_addr[ADDR_W-1:0];
                           rd_issue <= 1'b1;
                        end
                     end else begin
                        state <= ST_WR;
                        if (!core_busy && in_range) begin
                           mem_we    <= 1'b1;
                           mem_addr  <= ss_addr[ADDR_W-1:0];
                           mem_wdata <= ss_wdata[DATA_W-1:0];
                        end
                     end
                  end
               end
               ST_HDR: begin
                  if (hdr_rd) begin
                     ss_rdata <= ss_hdr_word(WCODE, LEN32);
                     ss_ack   <= 1'b1;
                     state    <= ST_ACK;
                  end else if (hdr_ok) begin
                     ss_ack <= 1'b1;
                     state  <= ST_ACK;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_RD_WAIT: begin
                  if (pend) begin
                     if (!core_busy) begin
                        if (!oor) mem_addr <= p_addr;
                        rd_issue <= 1'b1;
                        pend     <= 1'b0;
                     end
                  end else if (rd_valid) begin
                     ss_rdata <= oor ? 64'd0 : 64'(mem_rdata);
                     ss_ack   <= 1'b1;
                     state    <= ST_ACK;
                  end
               end
               ST_WR: begin
                  if (pend) begin
                     if (!core_busy) begin
                        if (!oor) begin
                           mem_we    <= 1'b1;
                           mem_addr  <= p_addr;
                           mem_wdata <= p_wdata;
                        end
                        pend <= 1'b0;
                     end
                  end else begin
                     ss_ack <= 1'b1;
                     state  <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  ss_ack <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ss_chunk_endpoint.sv
// Scoreboard bench for ss_chunk_endpoint (WIDTH_CODE=1, LENGTH=4096, READ_LATENCY=2) with a RAM model.
module tb_ss_chunk_endpoint;
   import ss_pkg::*;

   localparam int unsigned RL = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ss_select, ss_query, ss_wr_req, ss_rd_req;
   logic [31:0] ss_addr;
   logic [63:0] ss_wdata;
   logic [63:0] ss_rdata;
   logic        ss_ack;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
`ifdef SS_CORE_ARB_EN
   logic [11:0] core_addr;
   logic        core_we;
   logic [15:0] core_wdata;
   logic        core_req;
`endif

   ss_chunk_endpoint #(.ADDR_W(12), .WIDTH_CODE(1), .LENGTH(4096), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .ss_select(ss_select), .ss_query(ss_query),
      .ss_wr_req(ss_wr_req), .ss_rd_req(ss_rd_req), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
      .ss_rdata(ss_rdata), .ss_ack(ss_ack), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SS_CORE_ARB_EN
      , .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata), .core_req(core_req)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous RAM with RL-cycle read latency.
   logic [15:0] ram [4096];
   logic [15:0] rd_q [RL];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      rd_q[0] <= ram[mem_addr];
      for (int i = 1; i < int'(RL); i++) rd_q[i] <= rd_q[i-1];
   end
   assign mem_rdata = rd_q[RL-1];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          chk;
      logic [63:0] data;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int          we_cnt = 0;
   int          we_cyc = 0;
   int          ack_cyc = 0;
   logic [11:0] we_addr;
   logic [15:0] we_data;

   // Output monitor: every ack must match the oldest expectation in latency and data.
   always @(negedge clk) begin
      exp_t e;
      if (mem_we) begin
         we_cnt++;
         we_cyc  = cyc;
         we_addr = mem_addr;
         we_data = mem_wdata;
      end
      if (!reset && ss_ack) begin
         ack_cyc = cyc;
         check("ack_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_latency", 64'(cyc - e.acc - 1), 64'(e.lat));
            if (e.chk) check("rdata", ss_rdata, e.data);
         end
      end
   end

   task automatic start_req(input logic rd, input logic q, input logic [31:0] addr,
                            input logic [63:0] wd, input bit exp_ack, input bit chk,
                            input logic [63:0] exp_d, input int exp_lat);
      exp_t e;
      ss_select = 1'b1;
      ss_rd_req = rd;
      ss_wr_req = ~rd;
      ss_query  = q;
      ss_addr   = addr;
      ss_wdata  = wd;
      if (exp_ack) begin
         e = '{chk, exp_d, cyc, exp_lat};
         sb.push_back(e);
      end
   endtask

   task automatic finish_req(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         seen = ss_ack;
      end
      ss_rd_req = 1'b0;
      ss_wr_req = 1'b0;
      ss_query  = 1'b0;
      @(negedge clk);
   endtask

   task automatic xfer(input string tag, input logic rd, input logic q, input logic [31:0] addr,
                       input logic [63:0] wd, input bit exp_ack, input bit chk,
                       input logic [63:0] exp_d, input int exp_lat);
      bit seen;
      start_req(rd, q, addr, wd, exp_ack, chk, exp_d, exp_lat);
      finish_req(int'(SS_TIMEOUT), seen);
      check(tag, 64'(seen), 64'(exp_ack));
   endtask

   task automatic write_chk(input string tag, input logic [31:0] addr, input logic [15:0] d);
      int n0 = we_cnt;
      xfer(tag, 1'b0, 1'b0, addr, {48'hDEAD_0000_0000, d}, 1'b1, 1'b0, 64'd0, 1);
      check({tag, "_we_cnt"}, 64'(we_cnt - n0), 64'd1);
      check({tag, "_we_data"}, 64'(we_data), 64'(d));
      check({tag, "_we_addr"}, 64'(we_addr), 64'(addr[11:0]));
      check({tag, "_we_to_ack"}, 64'(ack_cyc - we_cyc), 64'd1);
   endtask

   initial begin
      int          n0;
      logic [11:0] ra;
      logic [15:0] rdv;
      bit          seen;

      reset = 1'b1;
      ss_select = 1'b0; ss_query = 1'b0; ss_wr_req = 1'b0; ss_rd_req = 1'b0;
      ss_addr = '0; ss_wdata = '0;
`ifdef SS_CORE_ARB_EN
      core_addr = '0; core_we = 1'b0; core_wdata = '0; core_req = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(ss_ack), 64'd0);
      check("rst_rdata", ss_rdata, 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Header fetch and header checks
      xfer("hdr_fetch", 1'b1, 1'b1, 32'd0, 64'd0, 1'b1, 1'b1, 64'h1_0000_1000, 1);
      check("hdr_index", 64'(ss_rdata[SS_HDR_INDEX_MSB:SS_HDR_INDEX_LSB]), 64'd0);
      check("hdr_not_end", 64'(ss_rdata != SS_END_MARKER), 64'd1);
      xfer("hdr_ok", 1'b0, 1'b1, 32'd0, 64'h1_0000_1000, 1'b1, 1'b0, 64'd0, 1);
      xfer("hdr_bad_len", 1'b0, 1'b1, 32'd0, 64'h1_0000_0FFF, 1'b0, 1'b0, 64'd0, 0);
      xfer("hdr_bad_width", 1'b0, 1'b1, 32'd0, 64'h2_0000_1000, 1'b0, 1'b0, 64'd0, 0);

      // Element writes and reads
      write_chk("wr5", 32'd5, 16'hBEEF);
      write_chk("wr0", 32'd0, 16'hA5A5);
      write_chk("wr7", 32'd7, 16'h1234);
      write_chk("wr4095", 32'd4095, 16'h0F0F);
      xfer("rd5", 1'b1, 1'b0, 32'd5, 64'd0, 1'b1, 1'b1, 64'h0000_0000_0000_BEEF, RL + 1);
      xfer("rd7", 1'b1, 1'b0, 32'd7, 64'd0, 1'b1, 1'b1, 64'h1234, RL + 1);
      xfer("rd0", 1'b1, 1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 64'hA5A5, RL + 1);
      xfer("rd4095", 1'b1, 1'b0, 32'd4095, 64'd0, 1'b1, 1'b1, 64'h0F0F, RL + 1);

      // Read wins when both requests are raised
      n0 = we_cnt;
      start_req(1'b1, 1'b0, 32'd5, 64'h7777, 1'b1, 1'b1, 64'hBEEF, RL + 1);
      ss_wr_req = 1'b1;
      finish_req(int'(SS_TIMEOUT), seen);
      check("both_ack", 64'(seen), 64'd1);
      check("both_no_we", 64'(we_cnt - n0), 64'd0);

      // Out-of-range accesses
      xfer("oor_rd", 1'b1, 1'b0, 32'd4096, 64'd0, 1'b1, 1'b1, 64'd0, RL + 1);
      xfer("oor_rd_hi", 1'b1, 1'b0, 32'h0001_0005, 64'd0, 1'b1, 1'b1, 64'd0, RL + 1);
      n0 = we_cnt;
      xfer("oor_wr", 1'b0, 1'b0, 32'd4096, 64'h5555, 1'b1, 1'b0, 64'd0, 1);
      check("oor_wr_no_we", 64'(we_cnt - n0), 64'd0);
      xfer("rd0_after_oor", 1'b1, 1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 64'hA5A5, RL + 1);

      // Random write/readback
      for (int i = 0; i < 6; i++) begin
         ra  = 12'($urandom_range(8, 4094));
         rdv = 16'($urandom);
         write_chk("rnd_wr", 32'(ra), rdv);
         xfer("rnd_rd", 1'b1, 1'b0, 32'(ra), 64'd0, 1'b1, 1'b1, 64'(rdv), RL + 1);
      end

      // Abort one cycle after accept; immediate follow-up read must see clean timing
      start_req(1'b1, 1'b0, 32'd7, 64'd0, 1'b0, 1'b0, 64'd0, 0);
      @(negedge clk);
      ss_select = 1'b0;
      @(negedge clk);
      check("abort_no_ack", 64'(ss_ack), 64'd0);
      xfer("after_abort", 1'b1, 1'b0, 32'd5, 64'd0, 1'b1, 1'b1, 64'hBEEF, RL + 1);

      // Reset mid-read
      start_req(1'b1, 1'b0, 32'd7, 64'd0, 1'b0, 1'b0, 64'd0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_rdata", ss_rdata, 64'd0);
      check("midrst_ack", 64'(ss_ack), 64'd0);
      reset = 1'b0;
      ss_select = 1'b0; ss_rd_req = 1'b0;
      repeat (4) @(negedge clk);
      xfer("after_reset", 1'b1, 1'b0, 32'd7, 64'd0, 1'b1, 1'b1, 64'h1234, RL + 1);

`ifdef SS_CORE_ARB_EN
      // Core holds the port for three edges during an endpoint write
      n0 = we_cnt;
      core_req = 1'b1; core_addr = 12'd100; core_we = 1'b0; core_wdata = 16'h0;
      start_req(1'b0, 1'b0, 32'd9, 64'h0000_0000_0000_C0DE, 1'b1, 1'b0, 64'd0, 4);
      @(negedge clk);
      check("arb_mem_follows_core", 64'(mem_addr), 64'd100);
      check("arb_no_ep_we", 64'(we_cnt - n0), 64'd0);
      @(negedge clk);
      @(negedge clk);
      core_req = 1'b0;
      finish_req(int'(SS_TIMEOUT), seen);
      check("arb_wr_ack", 64'(seen), 64'd1);
      check("arb_we_cnt", 64'(we_cnt - n0), 64'd1);
      check("arb_we_data", 64'(we_data), 64'hC0DE);
      xfer("arb_rd9", 1'b1, 1'b0, 32'd9, 64'd0, 1'b1, 1'b1, 64'hC0DE, RL + 1);
`endif

      repeat (4) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
